// File: rtl/bsg_subtractor_iterative.sv
// rtl/bsg_subtractor_iterative.sv - multi-cycle wide unsigned subtractor, one slice per cycle, LSB slice first
// Optional signed flags (ovf_o, lt_signed_o) enabled by BSG_SUBTRACTOR_ITERATIVE_SIGNED_FLAGS_EN.
module bsg_subtractor_iterative #(
  parameter int width_p = 128,
  parameter int slice_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  output logic               v_o,
  input  logic               yumi_i,
  output logic [width_p-1:0] d_o,
`ifdef BSG_SUBTRACTOR_ITERATIVE_SIGNED_FLAGS_EN
  output logic               ovf_o,
  output logic               lt_signed_o,
`endif
  output logic               borrow_o
);

  localparam int n_lp = width_p / slice_p;
  localparam int k_w_lp = (n_lp > 1) ? $clog2(n_lp) : 1;
  localparam logic [k_w_lp-1:0] k_last_lp = k_w_lp'(n_lp - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e state_r, state_n;

  logic [width_p-1:0] a_r, b_r, res_r, res_n;
  logic [k_w_lp-1:0]  k_r;
  logic               borrow_r;
  logic [slice_p:0]   slice_diff;
  logic               last_slice;

  assign last_slice = (k_r == k_last_lp);

  // One slice of the subtraction; the extra top bit of slice_diff is the outgoing borrow.
  always_comb begin
    slice_diff = {1'b0, a_r[int'(k_r)*slice_p +: slice_p]}
               - {1'b0, b_r[int'(k_r)*slice_p +: slice_p]}
               - {{slice_p{1'b0}}, borrow_r};
    res_n = res_r;
    res_n[int'(k_r)*slice_p +: slice_p] = slice_diff[slice_p-1:0];
  end

`ifdef BSG_SUBTRACTOR_ITERATIVE_SIGNED_FLAGS_EN
  logic ovf_n;
  assign ovf_n = (a_r[width_p-1] != b_r[width_p-1]) & (res_n[width_p-1] != a_r[width_p-1]);
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    ready_o = 1'b0;
    v_o     = 1'b0;
    case (state_r)
      IDLE: begin
        ready_o = 1'b1;
        if (v_i) state_n = BUSY;
      end
      BUSY: begin
        if (last_slice) state_n = DONE;
      end
      DONE: begin
        v_o = 1'b1;
        if (yumi_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      a_r         <= '0;
      b_r         <= '0;
      res_r       <= '0;
      k_r         <= '0;
      borrow_r    <= 1'b0;
      d_o         <= '0;
      borrow_o    <= 1'b0;
`ifdef BSG_SUBTRACTOR_ITERATIVE_SIGNED_FLAGS_EN
      ovf_o       <= 1'b0;
      lt_signed_o <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (v_i) begin
            a_r      <= a_i;
            b_r      <= b_i;
            borrow_r <= 1'b0;
            k_r      <= '0;
          end
        end
        BUSY: begin
          res_r    <= res_n;
          borrow_r <= slice_diff[slice_p];
          k_r      <= k_r + 1'b1;
          // Published outputs only change when the final slice lands.
          if (last_slice) begin
            d_o         <= res_n;
            borrow_o    <= slice_diff[slice_p];
`ifdef BSG_SUBTRACTOR_ITERATIVE_SIGNED_FLAGS_EN
            ovf_o       <= ovf_n;
            lt_signed_o <= res_n[width_p-1] ^ ovf_n;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bsg_subtractor_iterative.md
# bsg_subtractor_iterative

Multi-cycle unsigned subtractor that computes `d = a - b` and a final borrow over a wide operand. It processes one `slice_p`-bit slice per cycle, least-significant slice first, and holds the borrow between slices in a register. It is the inverse counterpart to the team's single-cycle wide adders, for datapaths where a full-width carry chain does not meet timing. Operands enter through a valid/ready handshake and results leave through a valid/yumi handshake.

## Interface
- `width_p`, default 128: operand and result width.
  - Must be an integer multiple of `slice_p`.
- `slice_p`, default 32: bits processed per cycle.
  - `N = width_p/slice_p` slices.
- `clk_i`: input, 1 bit. The block's single clock.
- `reset_n_i`: input, 1 bit. Reset is asynchronous and active-low.
- `v_i`: input, 1 bit. Operands valid.
- `ready_o`: output, 1 bit. The block can accept operands.
- `a_i`: input, `width_p` bits. Minuend, unsigned.
- `b_i`: input, `width_p` bits. Subtrahend, unsigned.
- `v_o`: output, 1 bit. Result valid.
- `yumi_i`: input, 1 bit. The consumer takes the result.
  - Legal only while `v_o` is 1.
- `d_o`: output, `width_p` bits. Difference `(a - b) mod 2^width_p`.
- `borrow_o`: output, 1 bit. 1 iff `a < b` (unsigned).
- `ovf_o`: output, 1 bit. Signed overflow. Present only with the configuration macro (see Configuration).
- `lt_signed_o`: output, 1 bit. 1 iff `a < b` (two's complement). Present only with the configuration macro.

## Operation
- States are IDLE, BUSY and DONE.
- **IDLE**
  - `ready_o` = 1.
  - On `v_i & ready_o`: latch `a_i` and `b_i`, clear the borrow register, clear the slice counter `k`, go to BUSY.
- **BUSY**
  - `ready_o` = 0.
  - Each cycle computes `{bo, diff} = a[k] - b[k] - borrow`, using `slice_p+1`-bit arithmetic.
  - `diff` is written into result slice `k`.
  - The borrow register takes `bo`.
  - `k` increments.
  - After the slice with `k = N-1` is written, go to DONE.
- **DONE**
  - `v_o` = 1.
  - `borrow_o` = final borrow.
  - `d_o` holds the full result.
  - On `yumi_i`: go to IDLE.
- Outputs `d_o` and `borrow_o` are registered. They stay stable through DONE and keep their last values in IDLE and BUSY until the next DONE.
- Boundary behaviour:
  - `v_i` outside IDLE: ignored.
  - `yumi_i` while `v_o` = 0: ignored.
  - `a == b`: `d_o` = 0, `borrow_o` = 0.
  - A borrow crossing a slice boundary is carried correctly through every intermediate slice.
  - `slice_p == width_p` (N = 1) is legal and gives exactly one BUSY cycle.
- Reset assertion, at any time:
  - State goes to IDLE.
  - `v_o`, `d_o`, `borrow_o`, `ovf_o`, `lt_signed_o`, borrow register and `k` go to 0.
  - An in-flight operation is discarded and no result is produced.
  - `ready_o` = 1 from reset onward.

## Timing
- Operands are accepted at clock edge T.
- BUSY occupies the cycles after edges T+1 … T+N.
- `v_o` rises after edge T+N, i.e. N cycles after the accept edge.
- The yumi handshake at edge Y returns the block to IDLE. `ready_o` = 1 in the following cycle.
- Maximum throughput is one operation per N+2 cycles.
  - There is no accept in the same cycle as `yumi_i`.
- There is no combinational path from any input to any output, except `ready_o`, which is decoded from state only.

## Configuration
- Macro: `BSG_SUBTRACTOR_ITERATIVE_SIGNED_FLAGS_EN`.
- Defined:
  - Ports `ovf_o` and `lt_signed_o` exist.
  - They are registered together with `d_o` on entry to DONE.
  - `ovf_o = (a_msb != b_msb) & (d_msb != a_msb)`.
  - `lt_signed_o = d_msb ^ ovf_o`.
- Undefined:
  - Both ports are absent.
  - No flag logic is synthesized.
  - All other behaviour is identical.

## Test plan
Defaults `width_p=128`, `slice_p=32`, N=4.
- **Simple subtract:** `a=5`, `b=3`, accepted at edge T → `v_o`=1 after edge T+4, `d_o=2`, `borrow_o=0`.
- **Underflow:** `a=0`, `b=1` → `d_o` all ones, `borrow_o=1`.
- **Cross-slice borrow:**
  - `a=2^32`, `b=1` → `d_o=0x0000…0000_FFFFFFFF`, `borrow_o=0`.
  - `a=2^96`, `b=1` → lower 96 bits all ones, `borrow_o=0`.
- **Backpressure:** hold `yumi_i=0` for 10 cycles in DONE while pulsing `v_i` with new operands → `d_o`/`v_o` stable, `ready_o=0`, new operands ignored. Then raise `yumi_i` → `ready_o=1` the next cycle, and the next accepted operation produces its own correct result.
- **Reset mid-operation:** assert `reset_n_i` in the second BUSY cycle → `v_o=0` and `d_o=0` immediately. After deassertion `ready_o=1`, and no result appears without a new accept.
- **Signed flags (macro defined):** `a=0x8000…0000`, `b=1` → `d_o=0x7FFF…FFFF`, `ovf_o=1`, `lt_signed_o=1`, `borrow_o=0`.
